tile_wr_arbiter: RTL and testbench
==================================

// Module: tile_wr_arbiter
// PURPOSE
//  Sole owner of the write port (port A) of the 80x30 tile RAM in the Etch-A-Sketch display path.
//  Arbitrates between two writers:
//   - cursor trace writes: one tile per cursor move.
//   - full-screen erase sweep ("shake to clear"): writes CLR_CHAR to every visible tile.
//  Read port B and the pixel pipeline are untouched; only we/addr/din of port A are driven here.
// PARAMETERS
//  MAX_X     80     tiles per row (640/8)
//  MAX_Y     30     tile rows (480/16)
//  CLR_CHAR  7'h00  code written to every tile by the erase sweep
// PORTS
//  clk_100MHz  in   1   system clock
//  reset       in   1   asynchronous, active-high
//  clear_req   in   1   1-cycle pulse: start erase sweep
//  trace_en    in   1   level: trace writes permitted
//  trace_req   in   1   1-cycle pulse: cursor moved, write tile under cursor
//  cur_x       in   7   cursor tile column, 0..MAX_X-1
//  cur_y       in   5   cursor tile row, 0..MAX_Y-1
//  trace_char  in   7   code to write for a trace
//  ram_we      out  1   tile RAM port-A write enable (registered)
//  ram_addr    out  12  port-A address {row[4:0], col[6:0]} (registered)
//  ram_din     out  7   port-A write data (registered)
//  busy        out  1   high while an erase sweep or its flush is in progress
//  clear_done  out  1   1-cycle pulse on the cycle after the last sweep write
// BEHAVIOUR
//  Reset values: ram_we=0, ram_addr=0, ram_din=0, busy=0, clear_done=0.
//  Reset also forces state=IDLE, clears the pending-trace buffer and the sweep counters.
//  Any reset mid-sweep aborts immediately; no further writes occur.
//  FSM states IDLE, CLEAR, FLUSH:
//   IDLE:
//    - trace_req & trace_en & cur_x<MAX_X & cur_y<MAX_Y -> next cycle ram_we=1, ram_addr={cur_y,cur_x}, ram_din=trace_char (latency 1).
//    - Out-of-range cursor or trace_en=0: trace request dropped, ram_we stays 0.
//    - clear_req -> CLEAR; busy=1 from the next cycle.
//   CLEAR:
//    - One write per cycle, ram_din=CLR_CHAR, addresses in row-major order:
//      (0,0),(1,0)..(79,0),(0,1)..(79,29). Columns 80..127 are never written.
//    - Exactly MAX_X*MAX_Y = 2400 consecutive ram_we cycles.
//    - After the (79,29) write: clear_done pulses, then -> FLUSH if a trace is pending, else -> IDLE.
//    - clear_req during CLEAR is ignored (no restart).
//   FLUSH:
//    - One cycle; writes the pending trace if trace_en is high now, else discards it -> IDLE.
//    - busy deasserts when IDLE is re-entered.
//  Pending buffer:
//   - Single entry {x,y,char}; loaded by a valid trace_req during CLEAR.
//   - A newer request overwrites an older one (newest wins).
//  Simultaneous events:
//   - clear_req & trace_req in IDLE: clear wins; the trace is buffered and flushed after the sweep.
//   - trace_req on the last sweep cycle is buffered and flushed.
//  Widths: column counter 7b wraps at MAX_X-1 -> 0 with row increment; row counter 5b; no arithmetic overflow.
//  ram_we is never high for more than one writer in any cycle.
// STRUCTURE
//  Shared package/header (tile_pkg): MAX_X, MAX_Y, TILE_ADDR_W=12, CHAR_W=7, state encodings.
//  Sub-module tile_sweep_counter:
//   - inputs: start, step; outputs: col[6:0], row[4:0], last.
//   - row-major 2-D counter.
//  Arbiter FSM, pending buffer and output registers stay in this module.
// TESTING
//  1. Idle trace: cur=(5,3), char=7'h41, trace_req -> one cycle later we=1, addr=12'h185, din=7'h41; only one we cycle.
//  2. Full clear: clear_req -> 2400 consecutive we cycles, din=0:
//     - first addr 12'h000, last 12'hECF;
//     - no addr with col>=80;
//     - clear_done one cycle after the last write; busy low after.
//  3. Trace during sweep: trace_req at sweep write 100, cur=(10,2), then again at write 200, cur=(11,2):
//     - exactly one flush write after clear_done, addr 12'h10B.
//  4. Simultaneous clear_req+trace_req in IDLE, cur=(0,0), char=7'h2A:
//     - sweep first, then a single write of 7'h2A to 12'h000.
//  5. Reset asserted at sweep write 1000 -> outputs 0 on the same edge, no writes afterwards; next trace_req behaves as in test 1.
//  6. trace_en=0 or cur_x=80 with trace_req -> ram_we stays 0; trace_en dropped before FLUSH -> pending trace discarded.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared constants and types for the tile RAM write path (80x30 tiles, 7-bit codes).
package tile_pkg;
    localparam int MAX_X       = 80;
    localparam int MAX_Y       = 30;
    localparam int TILE_ADDR_W = 12;
    localparam int CHAR_W      = 7;
    localparam int COL_W       = 7;
    localparam int ROW_W       = 5;

    localparam logic [CHAR_W-1:0] CLR_CHAR = 7'h00;
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(MAX_X - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(MAX_Y - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [ROW_W-1:0]  y;
        logic [COL_W-1:0]  x;
        logic [CHAR_W-1:0] ch;
    } trace_t;
endpackage

// File: rtl/tile_sweep_counter.sv
// Row-major 2-D tile counter for the erase sweep; last flags the bottom-right tile.
module tile_sweep_counter
    import tile_pkg::*;
(
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (start) begin
            col <= '0;
            row <= '0;
        end else if (step) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= (row == LAST_ROW) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign last = (col == LAST_COL) && (row == LAST_ROW);
endmodule

// File: rtl/tile_wr_arbiter.sv
// Owns tile RAM port A: arbitrates cursor trace writes against the full-screen erase sweep.
module tile_wr_arbiter
    import tile_pkg::*;
(
    input  logic                   clk_100MHz,
    input  logic                   reset,
    input  logic                   clear_req,
    input  logic                   trace_en,
    input  logic                   trace_req,
    input  logic [COL_W-1:0]       cur_x,
    input  logic [ROW_W-1:0]       cur_y,
    input  logic [CHAR_W-1:0]      trace_char,
    output logic                   ram_we,
    output logic [TILE_ADDR_W-1:0] ram_addr,
    output logic [CHAR_W-1:0]      ram_din,
    output logic                   busy,
    output logic                   clear_done
);
    state_t           state;
    logic             swept;
    trace_t           pend;
    logic             pend_vld;
    trace_t           req;
    logic             trace_ok;
    logic [COL_W-1:0] sw_col;
    logic [ROW_W-1:0] sw_row;
    logic             sw_last;

    assign req      = '{y: cur_y, x: cur_x, ch: trace_char};
    assign trace_ok = trace_req && trace_en &&
                      (cur_x < COL_W'(MAX_X)) && (cur_y < ROW_W'(MAX_Y));

    tile_sweep_counter u_sweep (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .start      (state == IDLE && clear_req),
        .step       (state == CLEAR && !swept),
        .col        (sw_col),
        .row        (sw_row),
        .last       (sw_last)
    );

    // swept marks the extra CLEAR cycle that raises clear_done after the final write
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            swept      <= 1'b0;
            pend       <= '0;
            pend_vld   <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            ram_we     <= 1'b0;
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        swept    <= 1'b0;
                        pend     <= req;
                        pend_vld <= trace_ok;
                    end else if (trace_ok) begin
                        ram_we   <= 1'b1;
                        ram_addr <= {cur_y, cur_x};
                        ram_din  <= trace_char;
                    end
                end
                CLEAR: begin
                    if (trace_ok) begin
                        pend     <= req;
                        pend_vld <= 1'b1;
                    end
                    if (!swept) begin
                        ram_we   <= 1'b1;
                        ram_addr <= {sw_row, sw_col};
                        ram_din  <= CLR_CHAR;
                        swept    <= sw_last;
                    end else begin
                        clear_done <= 1'b1;
                        swept      <= 1'b0;
                        if (pend_vld || trace_ok) begin
                            state <= FLUSH;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    pend_vld <= 1'b0;
                    // a request arriving in this very cycle is newer than the buffered one
                    if (trace_ok) begin
                        ram_we   <= 1'b1;
                        ram_addr <= {cur_y, cur_x};
                        ram_din  <= trace_char;
                    end else if (pend_vld && trace_en) begin
                        ram_we   <= 1'b1;
                        ram_addr <= {pend.y, pend.x};
                        ram_din  <= pend.ch;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tile_wr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a tile-level write model.
module tb_tile_wr_arbiter;
    import tile_pkg::*;

    logic        clk_100MHz = 1'b0;
    logic        reset;
    logic        clear_req, trace_en, trace_req;
    logic [6:0]  cur_x, trace_char;
    logic [4:0]  cur_y;
    logic        ram_we, busy, clear_done;
    logic [11:0] ram_addr;
    logic [6:0]  ram_din;

    tile_wr_arbiter dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .clear_req  (clear_req),
        .trace_en   (trace_en),
        .trace_req  (trace_req),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .trace_char (trace_char),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .busy       (busy),
        .clear_done (clear_done)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: mode 0 idle, 1 sweeping tile idx, 2 clear_done cycle, 3 flush cycle
    int          m_mode = 0, m_idx = 0;
    bit          m_pend = 0;
    logic [6:0]  m_px, m_pc;
    logic [4:0]  m_py;
    bit          e_we = 0, e_done = 0, e_busy = 0;
    logic [11:0] e_addr;
    logic [6:0]  e_din;

    task automatic model_step();
        bit valid;
        valid  = trace_req && trace_en && (cur_x < 80) && (cur_y < 30);
        e_we   = 0;
        e_done = 0;
        if (reset) begin
            m_mode = 0; m_pend = 0; e_busy = 0;
            return;
        end
        case (m_mode)
            0: begin
                if (clear_req) begin
                    m_mode = 1; m_idx = 0; e_busy = 1; m_pend = valid;
                    m_px = cur_x; m_py = cur_y; m_pc = trace_char;
                end else if (valid) begin
                    e_we = 1; e_addr = {cur_y, cur_x}; e_din = trace_char;
                end
            end
            1: begin
                if (valid) begin m_pend = 1; m_px = cur_x; m_py = cur_y; m_pc = trace_char; end
                e_we   = 1;
                e_addr = {5'(m_idx / 80), 7'(m_idx % 80)};
                e_din  = 7'h00;
                m_idx++;
                if (m_idx == 80 * 30) m_mode = 2;
            end
            2: begin
                if (valid) begin m_pend = 1; m_px = cur_x; m_py = cur_y; m_pc = trace_char; end
                e_done = 1;
                if (m_pend) m_mode = 3;
                else begin m_mode = 0; e_busy = 0; end
            end
            default: begin
                if (valid) begin
                    e_we = 1; e_addr = {cur_y, cur_x}; e_din = trace_char;
                end else if (m_pend && trace_en) begin
                    e_we = 1; e_addr = {m_py, m_px}; e_din = m_pc;
                end
                m_pend = 0; m_mode = 0; e_busy = 0;
            end
        endcase
    endtask

    // Observation statistics for the scenario-level checks
    int          cyc_n = 0, we_cnt, bad_col, last_we_cyc, done_cyc, post_we;
    bit          seen_done;
    logic [11:0] first_addr, last_addr, post_addr;
    logic [6:0]  post_din;

    task automatic clr_stats();
        we_cnt = 0; bad_col = 0; last_we_cyc = -1; done_cyc = -1;
        post_we = 0; seen_done = 0; first_addr = 'x; last_addr = 'x;
        post_addr = 'x; post_din = 'x;
    endtask

    task automatic cyc(input bit clr, input bit en, input bit req, input int x, input int y,
                       input logic [6:0] ch);
        clear_req = clr; trace_en = en; trace_req = req;
        cur_x = x[6:0]; cur_y = y[4:0]; trace_char = ch;
        @(posedge clk_100MHz);
        model_step();
        #1;
        chk("we", ram_we, e_we);
        chk("busy", busy, e_busy);
        chk("clear_done", clear_done, e_done);
        if (e_we) begin
            chk("addr", ram_addr, e_addr);
            chk("din", ram_din, e_din);
        end
        cyc_n++;
        if (ram_we) begin
            we_cnt++;
            if (we_cnt == 1) first_addr = ram_addr;
            last_addr = ram_addr;
            last_we_cyc = cyc_n;
            if (ram_addr[6:0] >= 7'd80) bad_col++;
            if (seen_done) begin post_we++; post_addr = ram_addr; post_din = ram_din; end
        end
        if (clear_done) begin seen_done = 1; done_cyc = cyc_n; end
    endtask

    task automatic idle(input int n, input bit en);
        for (int i = 0; i < n; i++) cyc(0, en, 0, 0, 0, 7'h00);
    endtask

    initial begin
        reset = 1; clear_req = 0; trace_en = 0; trace_req = 0;
        cur_x = 0; cur_y = 0; trace_char = 0;
        #1;
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_din", ram_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", clear_done, 0);
        idle(2, 1);
        reset = 0;
        idle(2, 1);

        // 1: idle trace
        clr_stats();
        cyc(0, 1, 1, 5, 3, 7'h41);
        chk("t1_addr", ram_addr, 12'h185);
        chk("t1_din", ram_din, 7'h41);
        idle(3, 1);
        chk("t1_we_cnt", we_cnt, 1);

        // 2: full clear
        clr_stats();
        cyc(1, 1, 0, 0, 0, 7'h00);
        idle(2405, 1);
        chk("t2_we_cnt", we_cnt, 2400);
        chk("t2_first", first_addr, 12'h000);
        chk("t2_last", last_addr, 12'hECF);
        chk("t2_bad_col", bad_col, 0);
        chk("t2_done_gap", done_cyc - last_we_cyc, 1);
        chk("t2_busy_after", busy, 0);

        // 3: two traces during the sweep, newest wins
        clr_stats();
        cyc(1, 1, 0, 0, 0, 7'h00);
        for (int i = 0; i < 2405; i++) begin
            if (i == 100)      cyc(0, 1, 1, 10, 2, 7'h11);
            else if (i == 200) cyc(0, 1, 1, 11, 2, 7'h12);
            else               cyc(0, 1, 0, 0, 0, 7'h00);
        end
        chk("t3_flush_cnt", post_we, 1);
        chk("t3_flush_addr", post_addr, 12'h10B);
        chk("t3_flush_din", post_din, 7'h12);

        // 4: simultaneous clear and trace in idle
        clr_stats();
        cyc(1, 1, 1, 0, 0, 7'h2A);
        idle(2405, 1);
        chk("t4_we_cnt", we_cnt, 2401);
        chk("t4_flush_cnt", post_we, 1);
        chk("t4_flush_addr", post_addr, 12'h000);
        chk("t4_flush_din", post_din, 7'h2A);

        // 5: reset mid-sweep aborts immediately
        clr_stats();
        cyc(1, 1, 0, 0, 0, 7'h00);
        idle(1000, 1);
        #2 reset = 1;
        #1;
        chk("t5_we", ram_we, 0);
        chk("t5_addr", ram_addr, 0);
        chk("t5_busy", busy, 0);
        model_step();
        idle(2, 1);
        reset = 0;
        clr_stats();
        idle(20, 1);
        chk("t5_no_writes", we_cnt, 0);
        cyc(0, 1, 1, 5, 3, 7'h41);
        chk("t5_trace_addr", ram_addr, 12'h185);
        idle(2, 1);

        // 6: dropped traces
        clr_stats();
        cyc(0, 0, 1, 5, 3, 7'h41);
        cyc(0, 1, 1, 80, 3, 7'h41);
        cyc(0, 1, 1, 5, 30, 7'h41);
        idle(2, 1);
        chk("t6_dropped", we_cnt, 0);
        clr_stats();
        cyc(1, 1, 0, 0, 0, 7'h00);
        for (int i = 0; i < 2405; i++) begin
            if (i == 50) cyc(0, 1, 1, 7, 7, 7'h33);
            else         cyc(0, i < 60, 0, 0, 0, 7'h00);
        end
        chk("t6_discard", post_we, 0);

        // random traffic
        for (int i = 0; i < 9000; i++) begin
            int x, y;
            x = $urandom_range(0, 85);
            y = $urandom_range(0, 31);
            cyc(i == 5 || $urandom_range(0, 2999) == 0, $urandom_range(0, 7) != 0,
                $urandom_range(0, 3) == 0, x, y, 7'($urandom));
        end
        idle(2405, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
